// File: rtl/bin8_to_bcd_seq.sv
// bin8_to_bcd_seq: sequential 8-bit binary to 3-digit BCD converter (double dabble, one step per clock)
module bin8_to_bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_bcd,
    output logic [7:0]  out_bin,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      state;
    logic [7:0]  sh;
    logic [11:0] acc;
    logic [11:0] adj;
    logic [11:0] nxt;
    logic [2:0]  cnt;
    // one double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit
    always_comb begin
        adj[3:0]  = acc[3:0]  >= 4'd5 ? acc[3:0]  + 4'd3 : acc[3:0];
        adj[7:4]  = acc[7:4]  >= 4'd5 ? acc[7:4]  + 4'd3 : acc[7:4];
        adj[11:8] = acc[11:8] >= 4'd5 ? acc[11:8] + 4'd3 : acc[11:8];
        nxt       = {adj[10:0], sh[7]};
    end
    // control FSM with registered handshake outputs; out_bcd only loads on the final step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sh        <= 8'h00;
            acc       <= 12'h000;
            cnt       <= 3'd0;
            out_bcd   <= 12'h000;
            out_bin   <= 8'h00;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sh       <= in_data;
                    out_bin  <= in_data;
                    acc      <= 12'h000;
                    cnt      <= 3'd0;
                    state    <= SHIFT;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                SHIFT: begin
                    acc <= nxt;
                    sh  <= {sh[6:0], 1'b0};
                    cnt <= cnt == 3'd7 ? cnt : cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        out_bcd   <= nxt;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin8_to_bcd_seq.sv
// tb_bin8_to_bcd_seq: directed self-checking bench for bin8_to_bcd_seq
module tb_bin8_to_bcd_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_bcd;
    logic [7:0]  out_bin;
    logic        busy;
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    bin8_to_bcd_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_bin(out_bin), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int bcd_of(input int d);
        return ((d / 100) << 8) | (((d / 10) % 10) << 4) | (d % 10);
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("ready_timeout", int'(in_ready), 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 40);
        chk({tag, "_latency"}, n, 8);
    endtask

    task automatic accept(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        wait_ready();
        tick();
        in_valid = 1'b0;
    endtask

    task automatic convert(input string tag, input logic [7:0] d, input int exp);
        accept(d);
        wait_valid(tag);
        chk({tag, "_bcd"}, int'(out_bcd), exp);
        chk({tag, "_bin"}, int'(out_bin), int'(d));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_ready"}, int'(in_ready), 1);
        chk({tag, "_idle_valid"}, int'(out_valid), 0);
    endtask

    initial begin
        logic [7:0] stream [7] = '{8'd1, 8'd3, 8'd9, 8'd27, 8'd81, 8'd243, 8'd217};
        int         sexp   [7] = '{'h001, 'h003, 'h009, 'h027, 'h081, 'h243, 'h217};
        int prev_acc = 0;
        int seen = 0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_bcd", int'(out_bcd), 'h000);
        chk("rst_bin", int'(out_bin), 'h00);
        #10 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", int'(in_ready), 1);

        convert("zero", 8'd0, 'h000);

        accept(8'd255);
        chk("busy_shift", int'(busy), 1);
        chk("ready_shift", int'(in_ready), 0);
        chk("bcd_hold_shift", int'(out_bcd), 'h000);
        wait_valid("max");
        chk("max_bcd", int'(out_bcd), 'h255);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("max_idle_ready", int'(in_ready), 1);
        chk("max_idle_busy", int'(busy), 0);

        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_data = stream[k];
            wait_ready();
            tick();
            if (k > 0) chk("stream_spacing", cyc - prev_acc, 10);
            prev_acc = cyc;
            if (k < 6) in_data = stream[k + 1];
            wait_valid("stream");
            chk("stream_bcd", int'(out_bcd), sexp[k]);
            chk("stream_bin", int'(out_bin), int'(stream[k]));
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;

        accept(8'd100);
        wait_valid("hold");
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_bcd", int'(out_bcd), 'h100);
            chk("hold_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_release_valid", int'(out_valid), 0);
        chk("hold_release_ready", int'(in_ready), 1);

        out_ready = 1'b1;
        accept(8'd200);
        in_data  = 8'd7;
        in_valid = 1'b1;
        wait_valid("ign");
        chk("ign_bcd", int'(out_bcd), 'h200);
        chk("ign_bin", int'(out_bin), 'hc8);
        tick();
        chk("ign_idle", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("ign_accept7_bin", int'(out_bin), 7);
        chk("ign_accept7_busy", int'(busy), 1);
        wait_valid("seven");
        chk("seven_bcd", int'(out_bcd), 'h007);
        tick();
        out_ready = 1'b0;

        accept(8'd45);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(in_ready), 1);
        chk("abort_bcd", int'(out_bcd), 'h000);
        chk("abort_bin", int'(out_bin), 'h00);
        #7 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        convert("after_abort", 8'd138, 'h138);

        for (int d = 0; d < 256; d += 7) convert("sweep", 8'(d), bcd_of(d));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
